alu_exec_unit: RTL and testbench

//  Execute-stage ALU driven by the 6-bit ALUControl code from the ALU decoder.

---
 rtl/alu_exec_unit.sv | 165 ++++++++++++++++
 tb/tb_alu_exec_unit.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - execute-stage ALU with iterative signed multiplier and ECALL halt
module alu_exec_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             branch_taken,
  output logic             illegal_op,
  output logic             halt
);

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_MUL   = 6'b000010;
  localparam logic [5:0] OP_AND   = 6'b000011;
  localparam logic [5:0] OP_OR    = 6'b000100;
  localparam logic [5:0] OP_XOR   = 6'b000101;
  localparam logic [5:0] OP_SRL   = 6'b000110;
  localparam logic [5:0] OP_SLL   = 6'b000111;
  localparam logic [5:0] OP_SLT   = 6'b001100;
  localparam logic [5:0] OP_BEQ   = 6'b001001;
  localparam logic [5:0] OP_BNE   = 6'b001010;
  localparam logic [5:0] OP_BLT   = 6'b001011;
  localparam logic [5:0] OP_BGE   = 6'b001000;
  localparam logic [5:0] OP_ECALL = 6'b111111;

  localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_HALT
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   acc;
  logic [SHAMT_W-1:0] cnt;

  logic [WIDTH-1:0]   diff;
  logic               lt_signed;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_br;
  logic               alu_ill;
  logic [WIDTH-1:0]   acc_next;

  assign diff      = src_a - src_b;
  assign lt_signed = $signed(src_a) < $signed(src_b);
  assign shamt     = src_b[SHAMT_W-1:0];
  // Only the low WIDTH product bits are kept, so unsigned shift-add gives the signed result.
  assign acc_next  = mplier[0] ? (acc + mcand) : acc;

  always_comb begin
    alu_res = '0;
    alu_br  = 1'b0;
    alu_ill = 1'b0;
    case (alu_control)
      OP_ADD: alu_res = src_a + src_b;
      OP_SUB: alu_res = diff;
      OP_AND: alu_res = src_a & src_b;
      OP_OR:  alu_res = src_a | src_b;
      OP_XOR: alu_res = src_a ^ src_b;
      OP_SRL: alu_res = src_a >> shamt;
      OP_SLL: alu_res = src_a << shamt;
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, lt_signed};
      OP_BEQ: begin
        alu_res = diff;
        alu_br  = (src_a == src_b);
      end
      OP_BNE: begin
        alu_res = diff;
        alu_br  = (src_a != src_b);
      end
      OP_BLT: begin
        alu_res = diff;
        alu_br  = lt_signed;
      end
      OP_BGE: begin
        alu_res = diff;
        alu_br  = ~lt_signed;
      end
      OP_MUL, OP_ECALL: alu_res = '0;
      default: alu_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      result       <= '0;
      branch_taken <= 1'b0;
      illegal_op   <= 1'b0;
      halt         <= 1'b0;
      mcand        <= '0;
      mplier       <= '0;
      acc          <= '0;
      cnt          <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            if (alu_control == OP_MUL) begin
              mcand    <= src_a;
              mplier   <= src_b;
              acc      <= '0;
              cnt      <= '0;
              in_ready <= 1'b0;
              state    <= S_MUL;
            end else if (alu_control == OP_ECALL) begin
              out_valid    <= 1'b1;
              result       <= '0;
              branch_taken <= 1'b0;
              illegal_op   <= 1'b0;
              halt         <= 1'b1;
              in_ready     <= 1'b0;
              state        <= S_HALT;
            end else begin
              out_valid    <= 1'b1;
              result       <= alu_res;
              branch_taken <= alu_br;
              illegal_op   <= alu_ill;
            end
          end
        end
        S_MUL: begin
          // The last multiplier bit is folded straight into the result register.
          if (cnt == CNT_LAST) begin
            out_valid    <= 1'b1;
            result       <= acc_next;
            branch_taken <= 1'b0;
            illegal_op   <= 1'b0;
            in_ready     <= 1'b1;
            state        <= S_IDLE;
          end else begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
          end
        end
        S_HALT: begin
          in_ready <= 1'b0;
        end
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - directed self-checking bench for alu_exec_unit
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  alu_control;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        out_valid;
  logic [31:0] result;
  logic        branch_taken;
  logic        illegal_op;
  logic        halt;

  int errors = 0;
  int checks = 0;

  alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .alu_control  (alu_control),
    .src_a        (src_a),
    .src_b        (src_b),
    .out_valid    (out_valid),
    .result       (result),
    .branch_taken (branch_taken),
    .illegal_op   (illegal_op),
    .halt         (halt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic op_check(input string tag, input logic [5:0] code, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res,
                          input logic exp_br, input logic exp_ill);
    @(negedge clk);
    in_valid    = 1'b1;
    alu_control = code;
    src_a       = a;
    src_b       = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check({tag, ".out_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, ".result"}, result, exp_res);
    check({tag, ".branch_taken"}, {31'd0, branch_taken}, {31'd0, exp_br});
    check({tag, ".illegal_op"}, {31'd0, illegal_op}, {31'd0, exp_ill});
  endtask

  initial begin
    int k;
    int low_cnt;
    int ov_at;
    int late;
    int bad;
    logic [31:0] mres;
    logic        rdy_at;

    rst = 1'b1;
    in_valid = 1'b0;
    alu_control = 6'd0;
    src_a = 32'd0;
    src_b = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.in_ready", {31'd0, in_ready}, 32'd1);
    check("reset.out_valid", {31'd0, out_valid}, 32'd0);
    check("reset.result", result, 32'd0);
    check("reset.branch_taken", {31'd0, branch_taken}, 32'd0);
    check("reset.illegal_op", {31'd0, illegal_op}, 32'd0);
    check("reset.halt", {31'd0, halt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    op_check("add_wrap", 6'b000000, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 1'b0);
    op_check("sub_neg", 6'b000001, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFE, 1'b0, 1'b0);
    op_check("slt_neg", 6'b001100, 32'hFFFFFFFF, 32'h1, 32'h1, 1'b0, 1'b0);
    op_check("slt_pos", 6'b001100, 32'h1, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0);
    op_check("blt_taken", 6'b001011, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFE, 1'b1, 1'b0);
    op_check("bge_not", 6'b001000, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFE, 1'b0, 1'b0);
    op_check("beq_taken", 6'b001001, 32'h5, 32'h5, 32'h0, 1'b1, 1'b0);
    op_check("bne_taken", 6'b001010, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFE, 1'b1, 1'b0);
    op_check("and", 6'b000011, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0);
    op_check("or", 6'b000100, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0);
    op_check("xor", 6'b000101, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0);
    op_check("srl", 6'b000110, 32'h80000000, 32'h23, 32'h10000000, 1'b0, 1'b0);
    op_check("sll", 6'b000111, 32'h1, 32'h23, 32'h00000008, 1'b0, 1'b0);

    @(negedge clk);
    in_valid = 1'b1;
    alu_control = 6'b000000;
    src_a = 32'd10;
    src_b = 32'd20;
    @(posedge clk);
    #1;
    check("b2b1.out_valid", {31'd0, out_valid}, 32'd1);
    check("b2b1.result", result, 32'd30);
    alu_control = 6'b000001;
    @(posedge clk);
    #1;
    check("b2b2.out_valid", {31'd0, out_valid}, 32'd1);
    check("b2b2.result", result, 32'hFFFFFFF6);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("idle.out_valid", {31'd0, out_valid}, 32'd0);
    check("idle.result_hold", result, 32'hFFFFFFF6);

    @(negedge clk);
    in_valid = 1'b1;
    alu_control = 6'b000010;
    src_a = 32'hFFFFFFFD;
    src_b = 32'd7;
    @(posedge clk);
    #1;
    alu_control = 6'b000000;
    src_a = 32'd5;
    src_b = 32'd6;
    k = 1;
    low_cnt = 0;
    ov_at = 0;
    mres = 32'd0;
    rdy_at = 1'b0;
    while (k <= 40 && ov_at == 0) begin
      if (!in_ready) low_cnt++;
      if (out_valid) begin
        ov_at = k;
        mres = result;
        rdy_at = in_ready;
      end else begin
        @(posedge clk);
        #1;
        k++;
      end
    end
    check("mul.latency", ov_at, 32'd33);
    check("mul.result", mres, 32'hFFFFFFEB);
    check("mul.ready_on_done", {31'd0, rdy_at}, 32'd1);
    check("mul.ready_low_cycles", low_cnt, 32'd32);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("held_add.out_valid", {31'd0, out_valid}, 32'd1);
    check("held_add.result", result, 32'd11);

    @(negedge clk);
    in_valid = 1'b1;
    alu_control = 6'b000010;
    src_a = 32'd5;
    src_b = 32'd5;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midmul_rst.in_ready", {31'd0, in_ready}, 32'd1);
    check("midmul_rst.out_valid", {31'd0, out_valid}, 32'd0);
    check("midmul_rst.result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    late = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) late++;
    end
    check("midmul_rst.no_late_valid", late, 32'd0);

    op_check("add_small", 6'b000000, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0);
    op_check("illegal_15", 6'h15, 32'h12345678, 32'h1, 32'd0, 1'b0, 1'b1);

    @(negedge clk);
    in_valid = 1'b1;
    alu_control = 6'b111111;
    @(posedge clk);
    #1;
    alu_control = 6'b000000;
    src_a = 32'd9;
    src_b = 32'd9;
    check("ecall.out_valid", {31'd0, out_valid}, 32'd1);
    check("ecall.result", result, 32'd0);
    check("ecall.halt", {31'd0, halt}, 32'd1);
    check("ecall.in_ready", {31'd0, in_ready}, 32'd0);
    check("ecall.illegal_op", {31'd0, illegal_op}, 32'd0);
    bad = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (in_ready || out_valid || !halt || result != 32'd0) bad++;
    end
    check("halt.sticky", bad, 32'd0);
    in_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
